key_decoder: RTL and testbench
==============================

Name: key_decoder

Overview:
- Upstream stage between the stdin byte source and the game controller.
- Converts the raw per-cycle byte stream into clean game commands:
  - flap: level held for a window.
  - start: one-cycle pulse.
  - quit: sticky.
  - paused: toggle level.
- Parses the ANSI up-arrow sequence (ESC [ A) as a flap and a lone ESC as quit.
- Replaces the controller's ad-hoc keypress shift buffer.

Parameters:
- HOLD_LEN, 5: cycles the flap level stays high after one flap event.
- ESC_TIMEOUT, 3: idle cycles after ESC before it counts as a lone ESC (quit).
- CNT_W, 16: width of the saturating flap-event counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inp  in  8  raw byte sampled each cycle; 8'h00 means no key this cycle.
- flap  out  1  high for HOLD_LEN cycles after each accepted flap event.
- start  out  1  one-cycle pulse on the first accepted flap event since reset.
- quit  out  1  sticky, set by 'q' (8'h71) or a lone ESC.
- paused  out  1  toggled by 'p' (8'h70).
- flap_count  out  CNT_W  accepted flap events, saturating at all-ones.

Behaviour:
- Reset (async, rst=1): all outputs 0, parser in S_IDLE, hold and timeout counters 0, started flag 0. Every output is registered.
- Latency: a byte sampled at edge N produces its effect on outputs after edge N; a space at edge N gives flap=1 for cycles N+1..N+HOLD_LEN.
- Parser FSM:
  - S_IDLE:
    - space (8'h20) -> flap event.
    - 'q' -> quit<=1.
    - 'p' -> paused<=~paused.
    - ESC (8'h1B) -> S_ESC with tcnt<=0.
    - any other byte, or 8'h00 -> stay.
  - S_ESC:
    - '[' (8'h5B) -> S_CSI.
    - 8'h00 -> tcnt++; when tcnt reaches ESC_TIMEOUT-1: quit<=1, -> S_IDLE.
    - ESC -> stay, tcnt<=0.
    - other byte -> S_IDLE, byte discarded (not reinterpreted).
  - S_CSI:
    - 'A' (8'h41) -> flap event, -> S_IDLE.
    - 8'h00 -> stay; no timeout in CSI.
    - any other byte (other arrows, digits) -> S_IDLE, discarded.
- Flap event accepted only when paused=0 and quit=0. On acceptance:
  - hold<=HOLD_LEN (retrigger reloads, never adds).
  - flap_count++ unless all-ones.
  - If started=0: start<=1 for one cycle, started<=1.
- flap = (hold != 0); hold decrements each cycle while nonzero.
- Pause toggle to 1 clears hold immediately, so flap drops the next cycle.
- After quit=1:
  - All further bytes ignored except that the parser still returns to S_IDLE.
  - paused and flap_count freeze.
  - hold keeps decaying.
- Simultaneous events: only one byte arrives per cycle, so there are no intra-cycle conflicts. A retrigger on the same cycle hold would reach 0 reloads it, and flap stays high continuously.
- Reset mid-sequence (e.g. after ESC [) discards the partial sequence; a following 'A' is then an ordinary ignored byte.

Decomposition:
- Shared package `game_pkg`:
  - Key byte constants: KEY_SPACE, KEY_ESC, KEY_LBRACK, KEY_A, KEY_Q, KEY_P, KEY_NONE.
  - Parser state enum: S_IDLE, S_ESC, S_CSI.
  - HOLD_LEN default shared with the controller.
- One natural sub-module, `hold_timer`: a loadable down-counter with a nonzero flag, used for the flap hold window. The ESC timeout stays inline.

Test Plan:
- Space once, then 8'h00 -> start=1 only on cycle N+1; flap=1 for exactly cycles N+1..N+5; flap_count=1.
- Space at cycles 0 and 3 -> flap high continuously from 1..8; start pulses once; flap_count=2.
- Bytes 1B,5B,41 on consecutive cycles -> flap asserted starting after the 'A' edge; quit stays 0.
- 1B followed by 00,00,00 -> quit=1 after the third idle cycle; later spaces leave flap=0 and flap_count unchanged.
- 'p', space, 'p', space -> first space ignored (count unchanged); second space gives flap and count=1.
- 1B,5B then rst=1 asynchronously mid-cycle -> all outputs 0 immediately; a subsequent 41 gives no flap.

Source files
------------

// File: rtl/game_pkg.sv
//==============================================================================
// Module      : game_pkg
// Description : Key byte codes, parser states and shared timing defaults.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package game_pkg;

    localparam logic [7:0] KEY_NONE   = 8'h00;
    localparam logic [7:0] KEY_ESC    = 8'h1B;
    localparam logic [7:0] KEY_SPACE  = 8'h20;
    localparam logic [7:0] KEY_A      = 8'h41;
    localparam logic [7:0] KEY_LBRACK = 8'h5B;
    localparam logic [7:0] KEY_P      = 8'h70;
    localparam logic [7:0] KEY_Q      = 8'h71;

    // The game controller uses the same value for its flap hold window.
    localparam int HOLD_LEN_DEFAULT = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ESC  = 2'd1,
        S_CSI  = 2'd2
    } parse_state_t;

endpackage

`default_nettype wire

// File: rtl/key_decoder_hold_timer.sv
//==============================================================================
// Module      : hold_timer
// Description : Loadable down-counter with nonzero flag (flap hold window).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hold_timer #(
    parameter int LOAD_VAL = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clear_i,
    output logic busy_o
);

    localparam int W = $clog2(LOAD_VAL + 2);

    logic [W-1:0] cnt_q;

    // A reload replaces the remaining count rather than extending it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= W'(LOAD_VAL);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/key_decoder.sv
//==============================================================================
// Module      : key_decoder
// Description : Turns the raw stdin byte stream into flap/start/quit/pause.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module key_decoder
    import game_pkg::*;
#(
    parameter int HOLD_LEN    = HOLD_LEN_DEFAULT,
    parameter int ESC_TIMEOUT = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       inp,
    output logic             flap,
    output logic             start,
    output logic             quit,
    output logic             paused,
    output logic [CNT_W-1:0] flap_count
);

    localparam int TCNT_W = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(ESC_TIMEOUT - 1);

    parse_state_t      state_q;
    logic [TCNT_W-1:0] tcnt_q;
    logic              quit_q;
    logic              paused_q;
    logic              start_q;
    logic              started_q;
    logic [CNT_W-1:0]  count_q;

    logic flap_req;
    logic accept;
    logic pause_set;

    always_comb begin
        flap_req = 1'b0;
        if (!quit_q) begin
            case (state_q)
                S_IDLE:  flap_req = (inp == KEY_SPACE);
                S_CSI:   flap_req = (inp == KEY_A);
                default: flap_req = 1'b0;
            endcase
        end
        accept    = flap_req && !paused_q;
        pause_set = !quit_q && !paused_q && (state_q == S_IDLE) && (inp == KEY_P);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            quit_q    <= 1'b0;
            paused_q  <= 1'b0;
            start_q   <= 1'b0;
            started_q <= 1'b0;
            count_q   <= '0;
        end else begin
            start_q <= 1'b0;
            if (quit_q) begin
                // Once quit, only the parser keeps moving, back to idle.
                state_q <= S_IDLE;
                tcnt_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        case (inp)
                            KEY_Q:   quit_q   <= 1'b1;
                            KEY_P:   paused_q <= ~paused_q;
                            KEY_ESC: begin
                                state_q <= S_ESC;
                                tcnt_q  <= '0;
                            end
                            default: ;
                        endcase
                    end
                    S_ESC: begin
                        if (inp == KEY_LBRACK) begin
                            state_q <= S_CSI;
                        end else if (inp == KEY_NONE) begin
                            if (tcnt_q == TCNT_LAST) begin
                                quit_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                tcnt_q <= tcnt_q + 1'b1;
                            end
                        end else if (inp == KEY_ESC) begin
                            tcnt_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_CSI: begin
                        if (inp != KEY_NONE) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase

                if (accept) begin
                    if (count_q != '1) begin
                        count_q <= count_q + 1'b1;
                    end
                    if (!started_q) begin
                        start_q   <= 1'b1;
                        started_q <= 1'b1;
                    end
                end
            end
        end
    end

    hold_timer #(
        .LOAD_VAL (HOLD_LEN)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .clear_i (pause_set),
        .busy_o  (flap)
    );

    assign start      = start_q;
    assign quit       = quit_q;
    assign paused     = paused_q;
    assign flap_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_key_decoder.sv
//==============================================================================
// Module      : tb_key_decoder
// Description : Self-checking bench for key_decoder against a byte-level model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_key_decoder;

    localparam int HOLD_LEN    = 5;
    localparam int ESC_TIMEOUT = 3;
    localparam int CNT_W       = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       inp = 8'h00;
    logic             flap;
    logic             start;
    logic             quit;
    logic             paused;
    logic [CNT_W-1:0] flap_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending escape prefix kept as a byte queue.
    int      m_seq[$];
    int      m_idle;
    bit      m_quit, m_paused, m_start, m_started;
    int      m_hold;
    longint  m_count;

    key_decoder #(
        .HOLD_LEN    (HOLD_LEN),
        .ESC_TIMEOUT (ESC_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inp        (inp),
        .flap       (flap),
        .start      (start),
        .quit       (quit),
        .paused     (paused),
        .flap_count (flap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_seq.delete();
        m_idle    = 0;
        m_quit    = 0;
        m_paused  = 0;
        m_start   = 0;
        m_started = 0;
        m_hold    = 0;
        m_count   = 0;
    endfunction

    function automatic void model_step(input int b);
        bit ev  = 0;
        bit clr = 0;
        m_start = 0;
        if (m_quit) begin
            m_seq.delete();
        end else if (m_seq.size() == 0) begin
            if (b == 8'h20) ev = 1;
            else if (b == 8'h71) m_quit = 1;
            else if (b == 8'h70) begin
                m_paused = !m_paused;
                clr = m_paused;
            end else if (b == 8'h1B) begin
                m_seq.push_back(b);
                m_idle = 0;
            end
        end else if (m_seq.size() == 1) begin
            if (b == 8'h5B) m_seq.push_back(b);
            else if (b == 8'h00) begin
                m_idle++;
                if (m_idle == ESC_TIMEOUT) begin
                    m_quit = 1;
                    m_seq.delete();
                end
            end else if (b == 8'h1B) m_idle = 0;
            else m_seq.delete();
        end else begin
            if (b == 8'h41) begin
                ev = 1;
                m_seq.delete();
            end else if (b != 8'h00) m_seq.delete();
        end

        if (clr) m_hold = 0;
        else if (ev && !m_paused) begin
            m_hold = HOLD_LEN;
            if (m_count < (longint'(1) << CNT_W) - 1) m_count++;
            if (!m_started) begin
                m_start   = 1;
                m_started = 1;
            end
        end else if (m_hold > 0) m_hold--;
    endfunction

    task automatic check_outputs();
        check("flap",       {31'd0, flap},   {31'd0, m_hold > 0});
        check("start",      {31'd0, start},  {31'd0, m_start});
        check("quit",       {31'd0, quit},   {31'd0, m_quit});
        check("paused",     {31'd0, paused}, {31'd0, m_paused});
        check("flap_count", 32'(flap_count), 32'(m_count));
    endtask

    task automatic step(input logic [7:0] b);
        inp = b;
        @(posedge clk);
        model_step(int'(b));
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00);
    endtask

    // Reset asserted mid-cycle: outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        inp = 8'h00;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 99);
        if (r < 30) return 8'h00;
        if (r < 50) return 8'h20;
        if (r < 60) return 8'h1B;
        if (r < 68) return 8'h5B;
        if (r < 76) return 8'h41;
        if (r < 82) return 8'h70;
        if (r < 83) return 8'h71;
        return 8'($urandom_range(1, 255));
    endfunction

    initial begin
        model_reset();
        do_reset();

        // Single flap and hold window
        step(8'h20);
        idle(7);
        do_reset();

        // Retrigger mid-window, then reload exactly as hold reaches zero
        step(8'h20); idle(2); step(8'h20); idle(4);
        step(8'h20); idle(6);

        // Up-arrow sequence
        step(8'h1B); step(8'h5B); step(8'h41); idle(6);

        // Lone ESC times out into quit; later flaps are ignored
        step(8'h1B); idle(3);
        step(8'h20); step(8'h20); step(8'h70); idle(2);
        do_reset();

        // Pause blocks a flap, unpause lets the next one through
        step(8'h70); step(8'h20); step(8'h70); step(8'h20); idle(2);
        // Pausing mid-window drops flap on the next cycle
        step(8'h70); idle(2); step(8'h70);

        // Reset in the middle of ESC [ discards the prefix
        step(8'h1B); step(8'h5B);
        do_reset();
        step(8'h41); idle(3);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            else step(rand_byte());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
